// File: rtl/axis_dwc_pkg.sv
// Shared definitions for the AXI-Stream data-width converters.
package axis_dwc_pkg;

    localparam int unsigned DEF_S_TDATA_WIDTH = 32;
    localparam int unsigned DEF_RATIO         = 2;

    // Upper bounds for the generic keep expansion helper.
    localparam int unsigned LANE_MAX = 64;
    localparam int unsigned KEEP_MAX = 512;

    // Lane index width; a ratio of 2 still needs one bit.
    function automatic int unsigned lane_idx_width(input int unsigned ratio);
        return (ratio <= 2) ? 1 : $clog2(ratio);
    endfunction

    // Expand a per-lane mask into byte enables, bytes_per_lane bits per lane, lane 0 in LSBs.
    function automatic logic [KEEP_MAX-1:0] keep_expand(input logic [LANE_MAX-1:0] mask,
                                                        input int unsigned bytes_per_lane);
        logic [KEEP_MAX-1:0] keep;
        logic [LANE_MAX-1:0] m;
        int unsigned         b;
        keep = '0;
        m    = mask;
        b    = 0;
        // Shift in from the top so the first generated bit ends up at bit 0.
        for (int unsigned k = 0; k < KEEP_MAX; k++) begin
            keep = {m[0], keep[KEEP_MAX-1:1]};
            b    = b + 1;
            if (b == bytes_per_lane) begin
                b = 0;
                m = m >> 1;
            end
        end
        return keep;
    endfunction

endpackage

// File: rtl/axis_dwidth_packer.sv
// AXI-Stream upsizer: packs RATIO narrow beats into one wide beat, flushing on tlast.
module axis_dwidth_packer
    import axis_dwc_pkg::*;
#(
    parameter int unsigned S_TDATA_WIDTH = DEF_S_TDATA_WIDTH,
    parameter int unsigned RATIO         = DEF_RATIO
) (
    input  logic                                   aclk,
    input  logic                                   areset,
    input  logic [S_TDATA_WIDTH-1:0]               s_axis_tdata,
    input  logic                                   s_axis_tvalid,
    input  logic                                   s_axis_tlast,
    output logic                                   s_axis_tready,
    output logic [S_TDATA_WIDTH*RATIO-1:0]         m_axis_tdata,
    output logic [S_TDATA_WIDTH*RATIO/8-1:0]       m_axis_tkeep,
    output logic                                   m_axis_tlast,
    output logic                                   m_axis_tvalid,
    input  logic                                   m_axis_tready,
    output logic [31:0]                            sts_partial_cnt
);

    localparam int unsigned M_TDATA_WIDTH = S_TDATA_WIDTH * RATIO;
    localparam int unsigned KEEP_W        = M_TDATA_WIDTH / 8;
    localparam int unsigned BPL           = S_TDATA_WIDTH / 8;
    localparam int unsigned IDX_W         = lane_idx_width(RATIO);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);

    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [M_TDATA_WIDTH-1:0] acc_q, acc_d, acc_m;
    logic [RATIO-1:0]         mask_q, mask_d, mask_m;

    logic [M_TDATA_WIDTH-1:0] data_q, data_d;
    logic [KEEP_W-1:0]        keep_q, keep_d;
    logic                     last_q, last_d;
    logic                     valid_q, valid_d;
    logic [31:0]              pcnt_q, pcnt_d;

    logic                     s_fire;
    logic                     completing;
    logic [KEEP_MAX-1:0]      keep_full;

    assign s_axis_tready   = !valid_q || m_axis_tready;
    assign m_axis_tdata    = data_q;
    assign m_axis_tkeep    = keep_q;
    assign m_axis_tlast    = last_q;
    assign m_axis_tvalid   = valid_q;
    assign sts_partial_cnt = pcnt_q;

    // Merge the current beat into its lane and compute next accumulator/output state.
    always_comb begin
        s_fire     = s_axis_tvalid && s_axis_tready;
        completing = s_fire && ((idx_q == IDX_LAST) || s_axis_tlast);

        acc_m  = acc_q;
        mask_m = mask_q;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (idx_q == IDX_W'(i)) begin
                acc_m[i*S_TDATA_WIDTH +: S_TDATA_WIDTH] = s_axis_tdata;
                mask_m[i]                               = 1'b1;
            end
        end
        keep_full = keep_expand(LANE_MAX'(mask_m), BPL);

        idx_d  = idx_q;
        acc_d  = acc_q;
        mask_d = mask_q;
        if (completing) begin
            idx_d  = '0;
            acc_d  = '0;
            mask_d = '0;
        end else if (s_fire) begin
            idx_d  = idx_q + IDX_W'(1);
            acc_d  = acc_m;
            mask_d = mask_m;
        end

        // Consume first, then a completing beat may reload in the same cycle.
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        valid_d = valid_q && !m_axis_tready;
        pcnt_d  = pcnt_q;
        if (completing) begin
            data_d  = acc_m;
            keep_d  = keep_full[KEEP_W-1:0];
            last_d  = s_axis_tlast;
            valid_d = 1'b1;
            if (idx_q != IDX_LAST) begin
                pcnt_d = pcnt_q + 32'd1;
            end
        end
    end

    // Accumulator: lane index, partial word and filled-lane mask.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            idx_q  <= '0;
            acc_q  <= '0;
            mask_q <= '0;
        end else begin
            idx_q  <= idx_d;
            acc_q  <= acc_d;
            mask_q <= mask_d;
        end
    end

    // Output register and partial-word counter.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            pcnt_q  <= '0;
        end else begin
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            pcnt_q  <= pcnt_d;
        end
    end

endmodule
